ballot_sequencer: RTL
=====================

# ballot_sequencer

Per-voter ballot controller for the 4-candidate EVM. It sits between the four button controllers and the vote logger. A presiding-officer `ballot_issue` pulse arms the booth for exactly one vote. The block accepts a single unambiguous candidate press, forwards it as a one-cycle one-hot strobe to the logger, then locks the booth for a confirmation period. Ballots that are ambiguous, cancelled or timed out are never forwarded.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: maximum cycles the booth stays armed without a vote. Must be ≥ 2.
- `CONFIRM_CYCLES`, default 50: length of the post-vote lockout. Must be ≥ 1.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `mode`  in  1  0 = voting, 1 = result display.
- `ballot_issue`  in  1  one-cycle pulse from the officer console (already debounced).
- `candidate_press`  in  4  one-cycle valid-vote pulses from the button controllers. Bit i is candidate i+1.
- `vote_strobe`  out  4  registered one-hot, one cycle per accepted vote; goes to the logger.
- `ballot_ready`  out  1  high while ARMED.
- `confirm_led`  out  1  high while CONFIRM.
- `ballot_timeout`  out  1  one-cycle pulse when an armed ballot expires.
- `ballots_cast`  out  8  count of accepted votes; saturates at 255.
- `rejected_count`  out  8  count of multi-press rejections; saturates at 255.

## Operation
- Reset values: state = IDLE; `vote_strobe` = 0; `ballot_ready` = 0; `confirm_led` = 0; `ballot_timeout` = 0; both counters = 0; internal timers = 0.
- States: IDLE, ARMED, CONFIRM. Outputs are decoded from registered state; `vote_strobe` and `ballot_timeout` are explicit registers.
- IDLE:
  - `mode`=0 and `ballot_issue`=1 → ARMED, arm timer cleared.
  - `candidate_press` is ignored.
- ARMED, evaluated in priority order each cycle:
  1. `mode`=1 → IDLE. Ballot cancelled, no strobe, no counter change.
  2. `candidate_press` has exactly one bit set → `vote_strobe` loads that bit, `ballots_cast`+1, CONFIRM, confirm timer cleared.
  3. `candidate_press` has ≥ 2 bits set → `rejected_count`+1. Stay ARMED; arm timer keeps running.
  4. Arm timer = TIMEOUT_CYCLES-1 → IDLE, `ballot_timeout` pulses.
  5. Otherwise the arm timer increments.
- `ballot_issue` while ARMED or CONFIRM is ignored; it does not re-arm or extend the ballot.
- CONFIRM: the confirm timer counts. At CONFIRM_CYCLES-1 → IDLE. Presses, `ballot_issue` and `mode` are ignored, so a logged vote always completes.
- Timer widths are `$clog2` of the respective parameter, with a minimum of 1 bit.
- Counters hold at 255 and do not wrap.
- Reset asserted in any state returns to the reset values on the next edge. A strobe pending in that cycle is dropped.

## Timing
- `ballot_issue` sampled at edge n → `ballot_ready`=1 from cycle n+1.
- Single press sampled at edge k (ARMED):
  - `vote_strobe` is high for cycle k+1 only.
  - `confirm_led` is high for cycles k+1 … k+CONFIRM_CYCLES.
  - `ballot_ready` drops at k+1.
  - IDLE at k+CONFIRM_CYCLES+1.
- Timeout: with no valid vote, `ballot_ready` is high for exactly TIMEOUT_CYCLES cycles. `ballot_timeout` is high on the first IDLE cycle.
- A valid press on the final ARMED cycle is accepted; it beats the timeout.
- `mode`=1 in the same cycle as a valid press in ARMED: the cancel wins and no strobe is issued.
- Counters update on the same edge that loads `vote_strobe` or records the rejection.
- Earliest re-arm is the cycle after returning to IDLE.

## Configuration
- Macro: `BALLOT_TIMEOUT_EN`.
- Defined: the arm timer and timeout transition exist as described.
- Not defined:
  - There is no arm timer; ARMED persists until a valid vote or `mode`=1.
  - `ballot_timeout` is tied to 0 and `TIMEOUT_CYCLES` is unused.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: TIMEOUT_CYCLES=20, CONFIRM_CYCLES=4, macro defined.
- Reset, then `ballot_issue`, then `candidate_press`=4'b0100 three cycles later → `vote_strobe`=4'b0100 for 1 cycle, `confirm_led` high 4 cycles, `ballots_cast`=1, IDLE afterward.
- Press 4'b0001 in IDLE, and press during CONFIRM → no strobe, `ballots_cast` unchanged.
- Arm, press 4'b0011, then 4'b1000 → `rejected_count`=1, strobe 4'b1000 only, `ballots_cast`=1.
- Arm, no press → `ballot_ready` high exactly 20 cycles, `ballot_timeout` 1-cycle pulse. A press on the 20th armed cycle instead yields a strobe and no timeout.
- Arm, then `mode`=1 together with press 4'b0010 → IDLE, no strobe, counters unchanged. Then `ballot_issue` with `mode`=1 → stays IDLE.
- 260 complete vote cycles → `ballots_cast` saturates at 255. Reset asserted mid-CONFIRM → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ballot_sequencer.sv
// -----------------------------------------------------------------------------
// ballot_sequencer
//
// Per-voter ballot controller for the 4-candidate EVM. A presiding-officer
// ballot_issue pulse arms the booth for one vote. A single unambiguous
// candidate press is forwarded to the vote logger as a one-cycle one-hot
// strobe, after which the booth is locked for a confirmation period.
// Ambiguous (multi-button), cancelled or timed-out ballots are never forwarded.
//
// Optional feature macro: BALLOT_TIMEOUT_EN
//   defined   : an armed ballot expires after TIMEOUT_CYCLES cycles without a
//               vote and ballot_timeout pulses for one cycle.
//   undefined : no arm timer; the booth stays armed until a vote or mode=1.
//               ballot_timeout is tied low and TIMEOUT_CYCLES is unused.
//
// Parameters:
//   TIMEOUT_CYCLES  max armed cycles without a vote (>= 2)
//   CONFIRM_CYCLES  post-vote lockout length (>= 1)
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   mode             in   0 = voting, 1 = result display
//   ballot_issue     in   one-cycle arm pulse from the officer console
//   candidate_press  in   [3:0] one-cycle press pulses, bit i = candidate i+1
//   vote_strobe      out  [3:0] registered one-hot, one cycle per accepted vote
//   ballot_ready     out  high while ARMED
//   confirm_led      out  high while CONFIRM
//   ballot_timeout   out  one-cycle pulse when an armed ballot expires
//   ballots_cast     out  [7:0] accepted votes, saturates at 255
//   rejected_count   out  [7:0] multi-press rejections, saturates at 255
// -----------------------------------------------------------------------------
module ballot_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CONFIRM_CYCLES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       ballot_issue,
  input  logic [3:0] candidate_press,
  output logic [3:0] vote_strobe,
  output logic       ballot_ready,
  output logic       confirm_led,
  output logic       ballot_timeout,
  output logic [7:0] ballots_cast,
  output logic [7:0] rejected_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CONFIRM
  } state_t;

  localparam int CW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CYCLES - 1);

`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_arm_timer;
  logic          r_timeout;
`endif

  state_t        r_state;
  logic [CW-1:0] r_confirm_timer;
  logic [3:0]    r_vote_strobe;
  logic [7:0]    r_ballots_cast;
  logic [7:0]    r_rejected_count;

  // x & (x-1) clears the lowest set bit: non-zero means two or more presses.
  logic [3:0] w_press_minus1;
  logic       w_multi_press;
  logic       w_single_press;

  assign w_press_minus1 = candidate_press - 4'd1;
  assign w_multi_press  = (candidate_press & w_press_minus1) != 4'd0;
  assign w_single_press = (candidate_press != 4'd0) && !w_multi_press;

  always_ff @(posedge clock) begin
    // NOTE: every state register uses <= so all of them update from the values
    // sampled at the same edge; = here would leak new values into later lines.
    if (reset) begin
      r_state          <= ST_IDLE;
      r_confirm_timer  <= '0;
      r_vote_strobe    <= 4'd0;
      r_ballots_cast   <= 8'd0;
      r_rejected_count <= 8'd0;
`ifdef BALLOT_TIMEOUT_EN
      r_arm_timer      <= '0;
      r_timeout        <= 1'b0;
`endif
    end else begin
      // Strobe and timeout are single-cycle pulses unless reloaded below.
      r_vote_strobe <= 4'd0;
`ifdef BALLOT_TIMEOUT_EN
      r_timeout     <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!mode && ballot_issue) begin
            r_state <= ST_ARMED;
`ifdef BALLOT_TIMEOUT_EN
            r_arm_timer <= '0;
`endif
          end
        end

        ST_ARMED: begin
          if (mode) begin
            // Cancel beats a simultaneous press.
            r_state <= ST_IDLE;
          end else if (w_single_press) begin
            // A press on the last armed cycle still wins over the timeout.
            r_vote_strobe   <= candidate_press;
            r_state         <= ST_CONFIRM;
            r_confirm_timer <= '0;
            if (r_ballots_cast != 8'hFF) r_ballots_cast <= r_ballots_cast + 8'd1;
          end else if (w_multi_press) begin
            if (r_rejected_count != 8'hFF) r_rejected_count <= r_rejected_count + 8'd1;
`ifdef BALLOT_TIMEOUT_EN
            // Hold at the last count so the expiry fires on the next idle cycle
            // instead of wrapping past it.
            if (r_arm_timer != TIMEOUT_LAST) r_arm_timer <= r_arm_timer + TW'(1);
`endif
          end
`ifdef BALLOT_TIMEOUT_EN
          else if (r_arm_timer == TIMEOUT_LAST) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_arm_timer <= r_arm_timer + TW'(1);
          end
`endif
        end

        ST_CONFIRM: begin
          // Inputs are ignored so a logged vote always completes its lockout.
          if (r_confirm_timer == CONFIRM_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_confirm_timer <= r_confirm_timer + CW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vote_strobe    = r_vote_strobe;
  assign ballot_ready   = (r_state == ST_ARMED);
  assign confirm_led    = (r_state == ST_CONFIRM);
  assign ballots_cast   = r_ballots_cast;
  assign rejected_count = r_rejected_count;
`ifdef BALLOT_TIMEOUT_EN
  assign ballot_timeout = r_timeout;
`else
  assign ballot_timeout = 1'b0;
`endif

endmodule
